// File: rtl/ins_sequencer.sv
// ins_sequencer: fetches instructions from SRAM and holds each on ins_data for its execution time.
// Define INS_SEQ_PREFETCH_EN to overlap the next fetch with the last EXEC cycle.
module ins_sequencer #(
  parameter int INSWIDTH = 19,
  parameter int INS_ADDRWIDTH = 10,
  parameter int CNTWIDTH = 8,
  parameter logic [INSWIDTH-1:0] NOP_WORD = 19'h60000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [INS_ADDRWIDTH-1:0] cfg_base_addr,
  input  logic [CNTWIDTH-1:0]      cfg_mac_len,
  output logic                     ins_rd_en,
  output logic [INS_ADDRWIDTH-1:0] ins_addr,
  input  logic [INSWIDTH-1:0]      ins_rdata,
  output logic [INSWIDTH-1:0]      ins_data,
  output logic                     ins_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err_illegal
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, WAIT = 3'd2, EXEC = 3'd3, DONE = 3'd4;
  localparam logic [2:0] OP_MAC_R = 3'b001, OP_END = 3'b100, OP_MULTI = 3'b101;
`ifdef INS_SEQ_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif
  logic [2:0] state_q, state_d;
  logic [INS_ADDRWIDTH-1:0] pc_q, pc_d, ins_addr_q, ins_addr_d;
  logic [CNTWIDTH-1:0] mac_len_q, mac_len_d, hold_q, hold_d;
  logic [INSWIDTH-1:0] ins_data_q, ins_data_d, exec_word;
  logic rd_en_q, rd_en_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2:0] op_q, op_r, op_x;
  assign op_q = ins_data_q[INSWIDTH-1:INSWIDTH-3];
  assign op_r = ins_rdata[INSWIDTH-1:INSWIDTH-3];
  assign op_x = exec_word[INSWIDTH-1:INSWIDTH-3];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    mac_len_d = mac_len_q;
    hold_d = hold_q;
    err_d = err_q;
    exec_word = ins_data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        pc_d = cfg_base_addr;
        mac_len_d = (cfg_mac_len == '0) ? CNTWIDTH'(1) : cfg_mac_len;
        err_d = 1'b0;
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        pc_d = pc_q + 1'b1;
        state_d = (op_r[2:1] == 2'b11) ? IDLE : EXEC;
        err_d = err_q | (op_r[2:1] == 2'b11);
        exec_word = ins_rdata;
        hold_d = (op_r == OP_MAC_R || op_r == OP_MULTI) ? mac_len_q - 1'b1 : '0;
      end
      EXEC: begin
        hold_d = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        state_d = (hold_q != '0) ? EXEC : (op_q == OP_END) ? DONE : PF ? WAIT : FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    valid_d = state_d == EXEC;
    ins_data_d = valid_d ? exec_word : NOP_WORD;
    busy_d = state_d == FETCH || state_d == WAIT || state_d == EXEC;
    done_d = state_d == DONE;
    // with prefetch, the next read overlaps the final cycle of a non-END instruction
    rd_en_d = state_d == FETCH || (PF && valid_d && hold_d == '0 && op_x != OP_END);
    ins_addr_d = rd_en_d ? pc_d : ins_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      mac_len_q <= '0;
      hold_q <= '0;
      ins_data_q <= NOP_WORD;
      ins_addr_q <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      mac_len_q <= mac_len_d;
      hold_q <= hold_d;
      ins_data_q <= ins_data_d;
      ins_addr_q <= ins_addr_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign ins_rd_en = rd_en_q;
  assign ins_addr = ins_addr_q;
  assign ins_data = ins_data_q;
  assign ins_valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err_illegal = err_q;
endmodule

// File: tb/tb_ins_sequencer.sv
// tb_ins_sequencer: scoreboard bench; a program-level model predicts reads, executed words, done/err and busy per cycle.
module tb_ins_sequencer;
  localparam logic [18:0] NOP = 19'h60000;
`ifdef INS_SEQ_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif
  localparam int K_VAL = 0, K_DONE = 1, K_ERR = 2;
  typedef struct { int cyc; logic [9:0] addr; } rd_t;
  typedef struct { int kind; logic [18:0] word; int cyc; } ev_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b1, abort = 1'b0;
  logic [9:0] cfg_base_addr = '0, ins_addr;
  logic [7:0] cfg_mac_len = '0;
  logic [18:0] ins_rdata = '0, ins_data;
  logic ins_rd_en, ins_valid, busy, done, err_illegal;
  logic [18:0] mem [1024];
  rd_t rq[$];
  ev_t eq[$];
  int cyc = 0, n_chk = 0, n_fail = 0, busy_from = 1, busy_to = 0, done_cyc = -1;
  logic mon_en = 1'b0, err_prev = 1'b0;
  ins_sequencer dut (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_mac_len(cfg_mac_len), .ins_rd_en(ins_rd_en),
    .ins_addr(ins_addr), .ins_rdata(ins_rdata), .ins_data(ins_data), .ins_valid(ins_valid),
    .busy(busy), .done(done), .err_illegal(err_illegal));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ins_rd_en) ins_rdata <= mem[ins_addr];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    rd_t r;
    ev_t e;
    if (ins_rd_en === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_read", {32'(cyc), 22'(ins_addr)}, 64'hFFFF_FFFF);
      else begin
        r = rq.pop_front();
        chk("read_cyc_addr", {32'(cyc), 22'(ins_addr)}, {32'(r.cyc), 22'(r.addr)});
      end
    end
    if (ins_valid === 1'b1) begin
      if (eq.size() == 0) chk("unexpected_valid", {32'(cyc), 32'(ins_data)}, 64'hFFFF_FFFF);
      else begin
        e = eq.pop_front();
        chk("exec_kind_cyc_word", {8'(K_VAL), 24'(cyc), 32'(ins_data)}, {8'(e.kind), 24'(e.cyc), 32'(e.word)});
      end
    end else chk("idle_nop", 64'(ins_data), 64'(NOP));
    if (done === 1'b1) begin
      done_cyc = cyc;
      if (eq.size() == 0) chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      else begin
        e = eq.pop_front();
        chk("done_kind_cyc", {32'(K_DONE), 32'(cyc)}, {32'(e.kind), 32'(e.cyc)});
      end
    end
    if (err_illegal === 1'b1 && !err_prev) begin
      if (eq.size() == 0) chk("unexpected_err", 64'(cyc), 64'hFFFF_FFFF);
      else begin
        e = eq.pop_front();
        chk("err_kind_cyc", {32'(K_ERR), 32'(cyc)}, {32'(e.kind), 32'(e.cyc)});
      end
    end
    err_prev = err_illegal;
    chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask
  // Walks the program in mem from base, predicting every event by cycle; leaves start asserted for one cycle.
  task automatic issue(input logic [9:0] base, input logic [7:0] mlc, output int s, output int last, output int quiet);
    int t, n, ml;
    logic [9:0] pc;
    logic [18:0] w;
    logic [2:0] op;
    tick();
    s = cyc;
    start = 1'b1;
    cfg_base_addr = base;
    cfg_mac_len = mlc;
    ml = (mlc == 0) ? 1 : int'(mlc);
    t = s + 1;
    pc = base;
    last = t;
    quiet = t;
    busy_from = s + 1;
    for (int k = 0; k < 1100; k++) begin
      w = mem[pc];
      op = w[18:16];
      rq.push_back('{t, pc});
      if (op[2:1] == 2'b11) begin
        eq.push_back('{K_ERR, 19'h0, t + 2});
        busy_to = t + 1;
        last = t + 2;
        quiet = t + 1;
        break;
      end
      n = (op == 3'b001 || op == 3'b101) ? ml : 1;
      for (int i = 0; i < n; i++) eq.push_back('{K_VAL, w, t + 2 + i});
      if (op == 3'b100) begin
        eq.push_back('{K_DONE, 19'h0, t + 2 + n});
        busy_to = t + 1 + n;
        last = t + 2 + n;
        quiet = last;
        break;
      end
      t = t + n + 2 - PF;
      pc = pc + 1'b1;
    end
    tick();
    start = 1'b0;
    cfg_base_addr = 10'($urandom);
    cfg_mac_len = 8'($urandom);
    chk("err_cleared_on_start", 64'(err_illegal), 64'(0));
  endtask
  // Abort or reset takes effect after cycle a: later predictions are withdrawn.
  task automatic trim(input int a);
    while (rq.size() > 0 && rq[$].cyc > a) void'(rq.pop_back());
    while (eq.size() > 0 && eq[$].kind != K_ERR && eq[$].cyc > a) void'(eq.pop_back());
    busy_to = a;
  endtask
  function automatic logic [18:0] rnd_word(input logic [2:0] op);
    return {op, 16'($urandom)};
  endfunction
  initial begin
    int s, last, quiet, a, L, c;
    logic [9:0] b;
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b011; ops[4] = 3'b101;
    for (int i = 0; i < 1024; i++) mem[i] = 19'h40000;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_outputs", {ins_rd_en, 22'(ins_addr), 19'(ins_data), ins_valid, busy, done, err_illegal},
        {1'b0, 22'h0, NOP, 1'b0, 1'b0, 1'b0, 1'b0});
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    mem[10'h010] = 19'h01234; mem[10'h011] = 19'h1ABCD; mem[10'h012] = 19'h25555; mem[10'h013] = 19'h40000;
    issue(10'h010, 8'd3, s, last, quiet);
    wait_until(last + 1);
    chk("full_prog_done_cycle", 64'(done_cyc), 64'(s + 15 - 3 * PF));
    mem[10'h020] = 19'h70000;
    issue(10'h020, 8'd2, s, last, quiet);
    wait_until(last + 2);
    chk("illegal_sticky", {ins_valid, busy, err_illegal}, 3'b001);
    mem[10'h3FF] = 19'h0F0F0; mem[10'h000] = 19'h40001;
    issue(10'h3FF, 8'd1, s, last, quiet);
    wait_until(s + 3);
    start = 1'b1;
    cfg_base_addr = 10'h123;
    tick();
    start = 1'b0;
    wait_until(last + 1);
    mem[10'h100] = 19'h12222; mem[10'h101] = 19'h40000;
    issue(10'h100, 8'd200, s, last, quiet);
    a = s + 7;
    wait_until(a);
    abort = 1'b1;
    trim(a);
    tick();
    abort = 1'b0;
    chk("abort_outputs", {ins_data, ins_valid, busy, done}, {NOP, 1'b0, 1'b0, 1'b0});
    issue(10'h100, 8'd2, s, last, quiet);
    wait_until(last + 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("abort_beats_start", {ins_rd_en, busy}, 2'b00);
    issue(10'h100, 8'd50, s, last, quiet);
    a = s + 9;
    wait_until(a);
    rst_n = 1'b0;
    trim(a);
    tick();
    rst_n = 1'b1;
    chk("reset_midprog", {22'(ins_addr), ins_rd_en, ins_valid, busy}, {22'h0, 3'b000});
    for (int p = 0; p < 25; p++) begin
      b = 10'($urandom);
      L = $urandom_range(0, 4);
      for (int i = 0; i < L; i++) mem[10'(b + 10'(i))] = rnd_word(ops[$urandom_range(0, 4)]);
      mem[10'(b + 10'(L))] = ($urandom_range(0, 4) == 0) ? rnd_word(3'($urandom_range(6, 7))) : rnd_word(3'b100);
      issue(b, 8'($urandom_range(0, 5)), s, last, quiet);
      c = $urandom_range(s + 2, quiet);
      wait_until(c);
      start = 1'b1;
      cfg_base_addr = 10'($urandom);
      tick();
      start = 1'b0;
      wait_until(last + 1);
    end
    wait_until(cyc + 4);
    chk("queues_drained", {32'(rq.size()), 32'(eq.size())}, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
